issue_scheduler: RTL and testbench

Out-of-order issue scheduler between rename/dispatch and the execution units. Holds up to DEPTH dispatched micro-ops, captures operand values from the writeback broadcast, and issues up to two ready ops per cycle. Each issued op is bound to a specific free unit: one of N_AU arithmetic units, one of N_MUL multipliers, or the single LSU.

---
 rtl/issue_pkg.sv | 22 ++
 rtl/fu_select.sv | 39 +++
 rtl/issue_scheduler.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_issue_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// issue_pkg: shared types for the issue scheduler.
// Tag and data widths are module parameters, so the payload fields sit next to
// iq_entry_t inside issue_scheduler rather than in this package.
package issue_pkg;

    localparam int unsigned UNIT_IDX_W = 2;

    typedef enum logic [1:0] {
        CLS_AU  = 2'd0,
        CLS_MUL = 2'd1,
        CLS_LSU = 2'd2,
        CLS_RSV = 2'd3
    } op_class_t;

    typedef struct packed {
        logic      valid;
        op_class_t cls;
        logic      rs1_rdy;
        logic      rs2_rdy;
    } iq_entry_t;

endpackage

// File: rtl/fu_select.sv
// fu_select: picks one unit out of an availability mask.
// Build option ISSUE_RR_EN: the search starts at ptr and wraps to the low end;
// without it the lowest available index wins.
module fu_select
    import issue_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]          avail,
`ifdef ISSUE_RR_EN
    input  logic [UNIT_IDX_W-1:0] ptr,
`endif
    output logic                  gnt,
    output logic [UNIT_IDX_W-1:0] idx
);

    // First available unit in search order
    always_comb begin
        gnt = 1'b0;
        idx = '0;
`ifdef ISSUE_RR_EN
        // Units at or after the pointer take priority
        for (int k = 0; k < int'(N); k++) begin
            if (!gnt && avail[k] && k >= int'(ptr)) begin
                gnt = 1'b1;
                idx = UNIT_IDX_W'(k);
            end
        end
`endif
        // Lowest index (also the wrap-around pass in round-robin mode)
        for (int k = 0; k < int'(N); k++) begin
            if (!gnt && avail[k]) begin
                gnt = 1'b1;
                idx = UNIT_IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: age-ordered collapsing issue queue, two issue slots per cycle.
// Build option ISSUE_RR_EN: round-robin unit choice for the AU and MUL classes.
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned N_AU  = 3,
    parameter int unsigned N_MUL = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_class,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         in_rs1_valid,
    input  logic                         in_rs2_valid,
    input  logic [TAG_W-1:0]             in_rs1_tag,
    input  logic [TAG_W-1:0]             in_rs2_tag,
    input  logic [XLEN-1:0]              in_rs1_data,
    input  logic [XLEN-1:0]              in_rs2_data,
    input  logic                         wb_valid,
    input  logic [TAG_W-1:0]             wb_tag,
    input  logic [XLEN-1:0]              wb_data,
    input  logic [N_AU-1:0]              au_free,
    input  logic [N_MUL-1:0]             mul_free,
    input  logic                         lsu_free,
    output logic [1:0]                   iss_valid,
    output logic [3:0]                   iss_class,
    output logic [3:0]                   iss_unit,
    output logic [2*TAG_W-1:0]           iss_tag,
    output logic [2*XLEN-1:0]            iss_rs1,
    output logic [2*XLEN-1:0]            iss_rs2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        iq_entry_t        ctl;
        logic [TAG_W-1:0] tag;
        logic [TAG_W-1:0] rs1_tag;
        logic [TAG_W-1:0] rs2_tag;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
    } slot_t;

    slot_t                 ent_q [DEPTH];
    slot_t                 ent_d [DEPTH];
    logic [CNT_W-1:0]      count_q, count_d;
    logic [N_AU-1:0]       au_shadow_q, au_avail0, au_avail1, au_gm0, au_gm1;
    logic [N_MUL-1:0]      mul_shadow_q, mul_avail0, mul_avail1, mul_gm0, mul_gm1;
    logic                  lsu_shadow_q, lsu_avail0, lsu_avail1, lsu_gm0, lsu_gm1;
    logic [DEPTH-1:0]      elig;
    logic                  pick0, pick1, au_gnt0, au_gnt1, mul_gnt0, mul_gnt1;
    logic [IDX_W-1:0]      sel0, sel1;
    op_class_t             cls0, cls1;
    logic [UNIT_IDX_W-1:0] au_idx0, au_idx1, mul_idx0, mul_idx1;
    logic [3:0]            iss_class_d, iss_unit_d;
    logic [2*TAG_W-1:0]    iss_tag_d;
    logic [2*XLEN-1:0]     iss_rs1_d, iss_rs2_d;

    function automatic logic class_ok(op_class_t c, logic au, logic mul, logic lsu);
        case (c)
            CLS_AU:  return au;
            CLS_MUL: return mul;
            CLS_LSU: return lsu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] unit_of(op_class_t c, logic [1:0] au, logic [1:0] mul);
        case (c)
            CLS_AU:  return au;
            CLS_MUL: return mul;
            default: return 2'd0;
        endcase
    endfunction

    assign in_ready   = !rst && (count_q < CNT_W'(DEPTH));
    assign count      = count_q;
    // Units granted at the previous edge are still busy in the unit's view
    assign au_avail0  = au_free & ~au_shadow_q;
    assign mul_avail0 = mul_free & ~mul_shadow_q;
    assign lsu_avail0 = lsu_free & ~lsu_shadow_q;

`ifdef ISSUE_RR_EN
    logic [UNIT_IDX_W-1:0] au_ptr_q, au_ptr_d, mul_ptr_q, mul_ptr_d;

    function automatic logic [UNIT_IDX_W-1:0] ptr_next(logic [UNIT_IDX_W-1:0] idx, int n);
        return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
    endfunction

    // Pointer moves one past the latest grant of its class this cycle
    always_comb begin
        au_ptr_d  = au_ptr_q;
        mul_ptr_d = mul_ptr_q;
        if (pick1 && cls1 == CLS_AU)       au_ptr_d = ptr_next(au_idx1, int'(N_AU));
        else if (pick0 && cls0 == CLS_AU)  au_ptr_d = ptr_next(au_idx0, int'(N_AU));
        if (pick1 && cls1 == CLS_MUL)      mul_ptr_d = ptr_next(mul_idx1, int'(N_MUL));
        else if (pick0 && cls0 == CLS_MUL) mul_ptr_d = ptr_next(mul_idx0, int'(N_MUL));
    end
`endif

    fu_select #(.N(N_AU)) u_au_sel0 (
        .avail (au_avail0),
`ifdef ISSUE_RR_EN
        .ptr   (au_ptr_q),
`endif
        .gnt   (au_gnt0),
        .idx   (au_idx0)
    );

    fu_select #(.N(N_MUL)) u_mul_sel0 (
        .avail (mul_avail0),
`ifdef ISSUE_RR_EN
        .ptr   (mul_ptr_q),
`endif
        .gnt   (mul_gnt0),
        .idx   (mul_idx0)
    );

    // Eligible means both operands were already ready at the start of the cycle
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            elig[i] = ent_q[i].ctl.valid && ent_q[i].ctl.rs1_rdy && ent_q[i].ctl.rs2_rdy;
        end
    end

    // Slot 0: oldest eligible entry whose class has a unit; then remove that unit
    always_comb begin
        pick0 = 1'b0;
        sel0  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!pick0 && elig[i] &&
                class_ok(ent_q[i].ctl.cls, au_gnt0, mul_gnt0, lsu_avail0)) begin
                pick0 = 1'b1;
                sel0  = IDX_W'(i);
            end
        end
        cls0       = ent_q[sel0].ctl.cls;
        au_gm0     = (pick0 && cls0 == CLS_AU) ? (N_AU'(1) << au_idx0) : '0;
        mul_gm0    = (pick0 && cls0 == CLS_MUL) ? (N_MUL'(1) << mul_idx0) : '0;
        lsu_gm0    = pick0 && cls0 == CLS_LSU;
        au_avail1  = au_avail0 & ~au_gm0;
        mul_avail1 = mul_avail0 & ~mul_gm0;
        lsu_avail1 = lsu_avail0 & ~lsu_gm0;
    end

    fu_select #(.N(N_AU)) u_au_sel1 (
        .avail (au_avail1),
`ifdef ISSUE_RR_EN
        .ptr   (au_ptr_q),
`endif
        .gnt   (au_gnt1),
        .idx   (au_idx1)
    );

    fu_select #(.N(N_MUL)) u_mul_sel1 (
        .avail (mul_avail1),
`ifdef ISSUE_RR_EN
        .ptr   (mul_ptr_q),
`endif
        .gnt   (mul_gnt1),
        .idx   (mul_idx1)
    );

    // Slot 1: next oldest eligible entry using what slot 0 left over
    always_comb begin
        pick1 = 1'b0;
        sel1  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!pick1 && elig[i] && !(pick0 && sel0 == IDX_W'(i)) &&
                class_ok(ent_q[i].ctl.cls, au_gnt1, mul_gnt1, lsu_avail1)) begin
                pick1 = 1'b1;
                sel1  = IDX_W'(i);
            end
        end
        cls1    = ent_q[sel1].ctl.cls;
        au_gm1  = (pick1 && cls1 == CLS_AU) ? (N_AU'(1) << au_idx1) : '0;
        mul_gm1 = (pick1 && cls1 == CLS_MUL) ? (N_MUL'(1) << mul_idx1) : '0;
        lsu_gm1 = pick1 && cls1 == CLS_LSU;
    end

    // Compact survivors in age order, apply wakeup, append the new dispatch
    always_comb begin
        slot_t            e;
        logic [CNT_W-1:0] n;
        n = '0;
        e = '0;
        for (int i = 0; i < int'(DEPTH); i++) ent_d[i] = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            e = ent_q[i];
            if (wb_valid && !e.ctl.rs1_rdy && e.rs1_tag == wb_tag) begin
                e.ctl.rs1_rdy = 1'b1;
                e.rs1_data    = wb_data;
            end
            if (wb_valid && !e.ctl.rs2_rdy && e.rs2_tag == wb_tag) begin
                e.ctl.rs2_rdy = 1'b1;
                e.rs2_data    = wb_data;
            end
            if (e.ctl.valid && !(pick0 && sel0 == IDX_W'(i)) && !(pick1 && sel1 == IDX_W'(i))) begin
                ent_d[n[IDX_W-1:0]] = e;
                n = n + 1'b1;
            end
        end
        // Reserved class is accepted but dropped
        if (in_valid && in_ready && in_class != CLS_RSV) begin
            e             = '0;
            e.ctl.valid   = 1'b1;
            e.ctl.cls     = op_class_t'(in_class);
            e.tag         = in_tag;
            e.rs1_tag     = in_rs1_tag;
            e.rs2_tag     = in_rs2_tag;
            e.ctl.rs1_rdy = in_rs1_valid || (wb_valid && in_rs1_tag == wb_tag);
            e.ctl.rs2_rdy = in_rs2_valid || (wb_valid && in_rs2_tag == wb_tag);
            e.rs1_data    = in_rs1_valid ? in_rs1_data : wb_data;
            e.rs2_data    = in_rs2_valid ? in_rs2_data : wb_data;
            ent_d[n[IDX_W-1:0]] = e;
            n = n + 1'b1;
        end
        count_d = n;
    end

    // Issue bus contents; idle slots drive zeros
    always_comb begin
        iss_class_d = '0;
        iss_unit_d  = '0;
        iss_tag_d   = '0;
        iss_rs1_d   = '0;
        iss_rs2_d   = '0;
        if (pick0) begin
            iss_class_d[1:0]     = cls0;
            iss_unit_d[1:0]      = unit_of(cls0, au_idx0, mul_idx0);
            iss_tag_d[TAG_W-1:0] = ent_q[sel0].tag;
            iss_rs1_d[XLEN-1:0]  = ent_q[sel0].rs1_data;
            iss_rs2_d[XLEN-1:0]  = ent_q[sel0].rs2_data;
        end
        if (pick1) begin
            iss_class_d[3:2]           = cls1;
            iss_unit_d[3:2]            = unit_of(cls1, au_idx1, mul_idx1);
            iss_tag_d[2*TAG_W-1:TAG_W] = ent_q[sel1].tag;
            iss_rs1_d[2*XLEN-1:XLEN]   = ent_q[sel1].rs1_data;
            iss_rs2_d[2*XLEN-1:XLEN]   = ent_q[sel1].rs2_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
            count_q      <= '0;
            au_shadow_q  <= '0;
            mul_shadow_q <= '0;
            lsu_shadow_q <= 1'b0;
            iss_valid    <= '0;
            iss_class    <= '0;
            iss_unit     <= '0;
            iss_tag      <= '0;
            iss_rs1      <= '0;
            iss_rs2      <= '0;
`ifdef ISSUE_RR_EN
            au_ptr_q     <= '0;
            mul_ptr_q    <= '0;
`endif
        end else begin
            ent_q        <= ent_d;
            count_q      <= count_d;
            au_shadow_q  <= au_gm0 | au_gm1;
            mul_shadow_q <= mul_gm0 | mul_gm1;
            lsu_shadow_q <= lsu_gm0 | lsu_gm1;
            iss_valid    <= {pick1, pick0};
            iss_class    <= iss_class_d;
            iss_unit     <= iss_unit_d;
            iss_tag      <= iss_tag_d;
            iss_rs1      <= iss_rs1_d;
            iss_rs2      <= iss_rs2_d;
`ifdef ISSUE_RR_EN
            au_ptr_q     <= au_ptr_d;
            mul_ptr_q    <= mul_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed scenarios plus random traffic, checked against a
// queue-based model of the scheduling rules.
module tb_issue_scheduler;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int XLEN  = 32;
    localparam int N_AU  = 3;
    localparam int N_MUL = 3;
`ifdef ISSUE_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [1:0]        in_class;
    logic [TAG_W-1:0]  in_tag, in_rs1_tag, in_rs2_tag, wb_tag;
    logic              in_rs1_valid, in_rs2_valid, wb_valid, lsu_free;
    logic [XLEN-1:0]   in_rs1_data, in_rs2_data, wb_data;
    logic [N_AU-1:0]   au_free;
    logic [N_MUL-1:0]  mul_free;
    logic [1:0]        iss_valid;
    logic [3:0]        iss_class, iss_unit;
    logic [2*TAG_W-1:0] iss_tag;
    logic [2*XLEN-1:0] iss_rs1, iss_rs2;
    logic [2:0]        count;

    issue_scheduler #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .XLEN  (XLEN),
        .N_AU  (N_AU),
        .N_MUL (N_MUL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_class     (in_class),
        .in_tag       (in_tag),
        .in_rs1_valid (in_rs1_valid),
        .in_rs2_valid (in_rs2_valid),
        .in_rs1_tag   (in_rs1_tag),
        .in_rs2_tag   (in_rs2_tag),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .au_free      (au_free),
        .mul_free     (mul_free),
        .lsu_free     (lsu_free),
        .iss_valid    (iss_valid),
        .iss_class    (iss_class),
        .iss_unit     (iss_unit),
        .iss_tag      (iss_tag),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cls;
        logic [3:0] tag;
        bit         r1, r2;
        logic [3:0] t1, t2;
        logic [31:0] d1, d2;
    } op_t;

    op_t         q[$];
    bit [3:0]    m_au_sh, m_mul_sh;
    bit          m_lsu_sh;
    int          m_au_ptr, m_mul_ptr;
    bit [1:0]    e_valid;
    int          e_cls[2], e_unit[2];
    logic [3:0]  e_tag[2];
    logic [31:0] e_rs1[2], e_rs2[2];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic int pick_unit(bit [3:0] av, int n, int ptr);
        for (int k = 0; k < n; k++) begin
            int u = RR ? (ptr + k) % n : k;
            if (av[u]) return u;
        end
        return -1;
    endfunction

    // One clock edge of the reference behaviour, using the inputs held this cycle
    task automatic model_edge();
        bit [3:0] av_au, av_mul, nsh_au, nsh_mul;
        bit       av_lsu, nsh_lsu, acc;
        int       sel[2];
        int       start_cnt, hi, lo;
        op_t      o;
        e_valid = 2'b00;
        if (rst) begin
            q.delete();
            m_au_sh = 0; m_mul_sh = 0; m_lsu_sh = 0; m_au_ptr = 0; m_mul_ptr = 0;
            return;
        end
        av_au  = {1'b0, au_free} & ~m_au_sh;
        av_mul = {1'b0, mul_free} & ~m_mul_sh;
        av_lsu = lsu_free && !m_lsu_sh;
        nsh_au = 0; nsh_mul = 0; nsh_lsu = 0;
        sel[0] = -1; sel[1] = -1;
        start_cnt = q.size();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < q.size() && sel[s] < 0; i++) begin
                int u;
                u = -1;
                if (i == sel[0] || !(q[i].r1 && q[i].r2)) continue;
                case (q[i].cls)
                    0: u = pick_unit(av_au, N_AU, m_au_ptr);
                    1: u = pick_unit(av_mul, N_MUL, m_mul_ptr);
                    2: u = av_lsu ? 0 : -1;
                    default: u = -1;
                endcase
                if (u >= 0) begin
                    sel[s] = i; e_valid[s] = 1'b1; e_cls[s] = q[i].cls; e_unit[s] = u;
                    e_tag[s] = q[i].tag; e_rs1[s] = q[i].d1; e_rs2[s] = q[i].d2;
                    case (q[i].cls)
                        0: begin av_au[u] = 0; nsh_au[u] = 1; m_au_ptr = (u + 1) % N_AU; end
                        1: begin av_mul[u] = 0; nsh_mul[u] = 1; m_mul_ptr = (u + 1) % N_MUL; end
                        default: begin av_lsu = 0; nsh_lsu = 1; end
                    endcase
                end
            end
        end
        m_au_sh = nsh_au; m_mul_sh = nsh_mul; m_lsu_sh = nsh_lsu;
        hi = (sel[0] > sel[1]) ? sel[0] : sel[1];
        lo = (sel[0] > sel[1]) ? sel[1] : sel[0];
        if (hi >= 0) q.delete(hi);
        if (lo >= 0) q.delete(lo);
        foreach (q[i]) begin
            if (wb_valid && !q[i].r1 && q[i].t1 == wb_tag) begin q[i].r1 = 1; q[i].d1 = wb_data; end
            if (wb_valid && !q[i].r2 && q[i].t2 == wb_tag) begin q[i].r2 = 1; q[i].d2 = wb_data; end
        end
        acc = in_valid && start_cnt < DEPTH && in_class != 2'd3;
        if (acc) begin
            o.cls = int'(in_class); o.tag = in_tag; o.t1 = in_rs1_tag; o.t2 = in_rs2_tag;
            o.r1 = in_rs1_valid || (wb_valid && in_rs1_tag == wb_tag);
            o.r2 = in_rs2_valid || (wb_valid && in_rs2_tag == wb_tag);
            o.d1 = in_rs1_valid ? in_rs1_data : wb_data;
            o.d2 = in_rs2_valid ? in_rs2_data : wb_data;
            q.push_back(o);
        end
    endtask

    task automatic compare();
        check("count", 64'(count), 64'(q.size()));
        check("in_ready", 64'(in_ready), 64'(!rst && q.size() < DEPTH));
        for (int s = 0; s < 2; s++) begin
            check("iss_valid", 64'(iss_valid[s]), 64'(e_valid[s]));
            if (e_valid[s] && iss_valid[s]) begin
                check("iss_class", 64'(iss_class[2*s +: 2]), 64'(e_cls[s]));
                check("iss_unit", 64'(iss_unit[2*s +: 2]), 64'(e_unit[s]));
                check("iss_tag", 64'(iss_tag[TAG_W*s +: TAG_W]), 64'(e_tag[s]));
                check("iss_rs1", 64'(iss_rs1[XLEN*s +: XLEN]), 64'(e_rs1[s]));
                check("iss_rs2", 64'(iss_rs2[XLEN*s +: XLEN]), 64'(e_rs2[s]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle();
        in_valid = 0; in_class = 0; in_tag = 0; in_rs1_valid = 0; in_rs2_valid = 0;
        in_rs1_tag = 0; in_rs2_tag = 0; in_rs1_data = 0; in_rs2_data = 0;
        wb_valid = 0; wb_tag = 0; wb_data = 0;
    endtask

    task automatic set_op(int cls, int tag, bit v1, int t1, int d1, bit v2, int t2, int d2);
        in_valid = 1; in_class = 2'(cls); in_tag = 4'(tag);
        in_rs1_valid = v1; in_rs1_tag = 4'(t1); in_rs1_data = 32'(d1);
        in_rs2_valid = v2; in_rs2_tag = 4'(t2); in_rs2_data = 32'(d2);
    endtask

    task automatic wake(int tag, int data);
        wb_valid = 1; wb_tag = 4'(tag); wb_data = 32'(data);
    endtask

    initial begin
        int units[4];
        idle();
        rst = 1; au_free = 3'b111; mul_free = 3'b111; lsu_free = 1;

        // Reset held for three cycles
        repeat (3) step();
        rst = 0;
        #1;
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // Ready AU op issues one edge after enqueue
        set_op(0, 1, 1, 0, 10, 1, 0, 10);
        step();
        idle();
        step();
        check("au_unit0", 64'(iss_unit[1:0]), 64'd0);
        check("au_rs1", 64'(iss_rs1[31:0]), 64'd10);
        step();

        // Two LSU ops: the shadow mask spaces them two cycles apart
        set_op(2, 2, 1, 0, 20, 1, 0, 21);
        step();
        set_op(2, 3, 1, 0, 30, 1, 0, 31);
        step();
        idle();
        repeat (3) step();

        // MUL waits on tag 7, then wakes from the broadcast
        set_op(1, 3, 0, 7, 0, 1, 0, 5);
        step();
        idle();
        repeat (2) step();
        wake(7, 42);
        step();
        idle();
        step();
        check("mul_valid", 64'(iss_valid[0]), 64'd1);
        check("mul_rs1", 64'(iss_rs1[31:0]), 64'd42);
        step();

        // Fill with blocked ops, hold a fifth dispatch, then wake one
        for (int i = 0; i < 4; i++) begin
            set_op(0, 4 + i, 0, 8 + i, 0, 1, 0, 1);
            step();
        end
        set_op(0, 12, 1, 0, 77, 1, 0, 78);
        repeat (2) step();
        check("full_not_ready", 64'(in_ready), 64'd0);
        wake(8, 99);
        step();
        wb_valid = 0;
        step();
        check("ready_after_issue", 64'(in_ready), 64'd1);
        step();
        idle();
        for (int t = 9; t < 12; t++) begin
            wake(t, 100 + t);
            step();
        end
        idle();
        repeat (4) step();

        // One ready AU op every three cycles from a clean pointer
        rst = 1;
        step();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            set_op(0, k, 1, 0, k, 1, 0, k);
            step();
            idle();
            step();
            units[k] = iss_valid[0] ? int'(iss_unit[1:0]) : 9;
            step();
        end
        for (int k = 0; k < 4; k++) check("rr_unit", 64'(units[k]), 64'(RR ? k % 3 : 0));

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_class = 2'($urandom_range(0, 3));
            in_tag = 4'($urandom);
            in_rs1_valid = 1'($urandom_range(0, 1));
            in_rs2_valid = 1'($urandom_range(0, 1));
            in_rs1_tag = 4'($urandom_range(0, 7));
            in_rs2_tag = 4'($urandom_range(0, 7));
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            wb_valid = 1'($urandom_range(0, 1));
            wb_tag = 4'($urandom_range(0, 7));
            wb_data = $urandom;
            au_free = 3'($urandom);
            mul_free = 3'($urandom);
            lsu_free = 1'($urandom_range(0, 1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
